rns_dmem_ctrl: RTL
==================

// Module: rns_dmem_ctrl
// PURPOSE
// Parametrised data memory for the RNS-domain RISC core. Each entry holds one operand slice per RNS domain,
// packed MSB-first, so loads and stores never need deconstruction or reconstruction.
// Generalises the 256x16 dual-domain store: widths, depth and domain count are configurable.
// Adds a registered read port, per-domain write masking, write-first bypass and a post-reset clear sequencer.
// Sits between the execute stage (store data, load address) and the writeback mux.
// PARAMETERS
// DOM_W     8    bits per RNS domain slice
// NUM_DOM   2    number of RNS domains per entry; domain 0 occupies the MSBs
// ADDR_W    8    address width; DEPTH = 2**ADDR_W entries
// WORD_W    DOM_W*NUM_DOM  derived entry width (localparam, not overridable)
// PORTS
// clk        in   1        rising-edge clock
// rst        in   1        asynchronous, active-high reset
// rd_en      in   1        load request, sampled at posedge
// rd_addr    in   ADDR_W   load address
// rd_data    out  WORD_W   load data {dom0..domN-1}, registered
// rd_valid   out  1        rd_data valid this cycle
// wr_en      in   1        store request, sampled at posedge
// wr_addr    in   ADDR_W   store address
// wr_data    in   WORD_W   store data {dom0..domN-1}
// wr_dmask   in   NUM_DOM  per-domain write enable; bit NUM_DOM-1 = domain 0 (MSB slice)
// init_busy  out  1        clear sequence in progress; all requests ignored
// BEHAVIOUR
// - Reset (rst=1, async): rd_data=0, rd_valid=0, init_busy=1, FSM=CLEAR, clear pointer=0. Array is not reset directly.
// - FSM CLEAR: on each posedge, write all-zero to mem[clr_ptr]; clr_ptr++. init_busy=1.
//   Exits to READY on the edge that writes DEPTH-1; init_busy=0 the following cycle. Total DEPTH cycles.
// - While in CLEAR: rd_en/wr_en ignored, rd_valid stays 0, no user writes land.
// - rst asserted mid-CLEAR or mid-operation: immediately return to reset state; the clear restarts from address 0.
// - FSM READY: the only other state. It persists until rst.
// - Write (READY): at posedge with wr_en=1, for each domain d with mask bit set, the slice of mem[wr_addr] <= wr_data slice.
//   Slices whose mask bit is clear keep their old value. wr_dmask=0 is a legal no-op.
// - Read (READY): at posedge with rd_en=1, rd_data <= mem[rd_addr] and rd_valid <= 1. Latency is 1 cycle.
//   rd_en=0 -> rd_valid <= 0 and rd_data holds its last value.
// - Same-cycle rd/wr to the same address is write-first. rd_data returns the merged word: new slices where the mask
//   is set, old slices elsewhere.
// - Same-cycle rd/wr to different addresses are independent. Back-to-back reads give one result per cycle.
// - Addresses are full range, with no wrap or out-of-range case. The clear pointer wraps to 0 only via reset.
// - No X may propagate to rd_data after the first READY read.
// TESTING
// 1 rst pulse, defaults (DEPTH=256) -> init_busy=1 for exactly 256 cycles after rst falls;
//   a read of every address then returns 16'h0000.
// 2 wr_en addr 8'h10 data 16'hA55A mask 2'b11; next cycle rd addr 8'h10 -> one cycle later rd_data=16'hA55A, rd_valid=1.
// 3 Preload 8'h20=16'h1234; write 16'hFFEE with mask 2'b01 -> read returns 16'h12EE;
//   then mask 2'b10 with 16'h77xx -> 16'h77EE.
// 4 Same cycle: wr 8'h30=16'hBEEF mask 2'b10 (old 16'h0102), rd 8'h30 -> rd_data=16'hBE02 on the next edge.
// 5 rst reasserted at clear pointer 100, released -> init_busy lasts a full 256 cycles; rd_en during CLEAR yields rd_valid=0.
// 6 NUM_DOM=3, DOM_W=5, ADDR_W=4 -> 16-cycle clear; write 15'h7C1F mask 3'b101, read back 15'h7C1F, and verify masked slice stays 0.

Source files
------------

// File: rtl/rns_dmem_ctrl.sv
// rtl/rns_dmem_ctrl.sv - RNS-domain data memory with masked writes, write-first read and clear sequencer
module rns_dmem_ctrl #(
    parameter int DOM_W   = 8,
    parameter int NUM_DOM = 2,
    parameter int ADDR_W  = 8,
    localparam int WORD_W = DOM_W * NUM_DOM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [NUM_DOM-1:0] wr_dmask,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic [WORD_W-1:0]   mem [DEPTH];

    logic [WORD_W-1:0]   bit_mask;
    logic [WORD_W-1:0]   merged_wr;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;

    // Expand the per-domain mask to bit granularity; mask bit i covers slice i counted from the LSB end
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            bit_mask[i*DOM_W +: DOM_W] = {DOM_W{wr_dmask[i]}};
        end
    end

    // Word that a store produces: new slices where masked in, old slices elsewhere
    assign merged_wr = (mem[wr_addr] & ~bit_mask) | (wr_data & bit_mask);

    // Next-state, clear pointer, array write port and read-port next values
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = merged_wr;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                if (&clr_ptr_q) begin
                    state_d = ST_READY;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                mem_we = wr_en;
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    // Write-first: a colliding store is visible to the load in the same cycle
                    if (wr_en && (wr_addr == rd_addr)) begin
                        rd_data_d = merged_wr;
                    end else begin
                        rd_data_d = mem[rd_addr];
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Control and read-port registers; reset restarts the clear from address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array; not reset, the clear sequencer zeroes it instead
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = (state_q == ST_CLEAR);

endmodule
